// File: rtl/seq_barrel_rotator.sv
// Multi-cycle shift/rotate unit: one bit-step per clock under a start/ready/done handshake.
// Ops: ROR, ROL, SHR, SHL, ASR, plus pass-through; carry holds the last bit moved out.
module seq_barrel_rotator #(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  data_in,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          carry,
  output logic          zero,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ROR = 3'd0;
  localparam logic [2:0] OP_ROL = 3'd1;
  localparam logic [2:0] OP_SHR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_ASR = 3'd4;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [AW-1:0] cnt;
  logic [N-1:0]  step_res;
  logic          step_carry;
  logic          accept;
  logic          passthru;

  // Handshake: a request is taken on any rising edge where start=1 and ready=1
  // (IDLE or DONE); start while busy is dropped, and done pulses one cycle with result valid.
  assign ready     = (state != S_BUSY);
  assign busy      = (state == S_BUSY);
  assign done      = (state == S_DONE);
  assign zero      = (result == '0);
  assign dbg_state = state;
  assign accept    = start && ready;
  assign passthru  = (op > OP_ASR);

  always_comb begin
    step_res   = result;
    step_carry = carry;
    case (op_q)
      OP_ROR: begin step_res = {result[0], result[N-1:1]};   step_carry = result[0];   end
      OP_ROL: begin step_res = {result[N-2:0], result[N-1]}; step_carry = result[N-1]; end
      OP_SHR: begin step_res = {1'b0, result[N-1:1]};        step_carry = result[0];   end
      OP_SHL: begin step_res = {result[N-2:0], 1'b0};        step_carry = result[N-1]; end
      OP_ASR: begin step_res = {result[N-1], result[N-1:1]}; step_carry = result[0];   end
      default: begin step_res = result;                      step_carry = carry;       end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      cnt    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      result <= data_in;
      carry  <= 1'b0;
      op_q   <= op;
      cnt    <= amt;
      state  <= ((amt == '0) || passthru) ? S_DONE : S_BUSY;
    end else begin
      case (state)
        S_BUSY: begin
          result <= step_res;
          carry  <= step_carry;
          cnt    <= cnt - 1'b1;
          // cnt==1 means this edge takes the final step
          if (cnt == {{(AW-1){1'b0}}, 1'b1}) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_barrel_rotator.sv
// Directed bench for seq_barrel_rotator: latency, results, flags, back-to-back,
// ignored starts while busy, and asynchronous reset mid-operation.
module tb_seq_barrel_rotator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  amt;
  logic [15:0] data_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic [1:0]  dbg_state;

  int checks;
  int passed;

  seq_barrel_rotator #(.N(16), .AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .amt       (amt),
    .data_in   (data_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drives one request at a negedge; optional junk starts at busy-loop indices g1/g2.
  task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] a,
                        input logic [15:0] d, input logic [15:0] er, input logic ec,
                        input int elat, input int g1, input int g2);
    int cyc;
    int nbusy;
    chk({name, "_ready_before"}, ready, 1);
    start = 1'b1; op = o; amt = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7)); amt = 4'($urandom_range(0, 15));
    data_in = 16'($urandom_range(0, 65535));
    cyc = 0;
    nbusy = 0;
    while (!done && cyc < 100) begin
      if (busy) nbusy++;
      if (cyc == g1 || cyc == g2) begin
        start = 1'b1; op = 3'd3; amt = 4'd3; data_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, "_latency"}, cyc, elat);
    chk({name, "_busy_cycles"}, nbusy, elat);
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_result"}, result, er);
    chk({name, "_carry"}, carry, ec);
    chk({name, "_zero"}, zero, (er == 16'h0000));
  endtask

  task automatic after_done(input string name, input logic [15:0] er, input logic ec);
    @(negedge clk);
    chk({name, "_done_drop"}, done, 0);
    chk({name, "_ready_idle"}, ready, 1);
    chk({name, "_result_hold"}, result, er);
    chk({name, "_carry_hold"}, carry, ec);
  endtask

  initial begin
    checks = 0; passed = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; amt = 4'd0; data_in = 16'h0000;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 1);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("ror4", 3'd0, 4'd4, 16'h00FF, 16'hF00F, 1'b1, 4, -1, -1);
    after_done("ror4", 16'hF00F, 1'b1);

    run_op("asr1", 3'd4, 4'd1, 16'hC003, 16'hE001, 1'b1, 1, -1, -1);
    // issued in the DONE cycle of the ASR
    run_op("shr15", 3'd2, 4'd15, 16'hFF00, 16'h0001, 1'b1, 15, -1, -1);
    after_done("shr15", 16'h0001, 1'b1);

    run_op("rol8", 3'd1, 4'd8, 16'h3C0C, 16'h0C3C, 1'b0, 8, -1, -1);
    after_done("rol8", 16'h0C3C, 1'b0);
    run_op("shl1", 3'd3, 4'd1, 16'h0AAA, 16'h1554, 1'b0, 1, -1, -1);
    after_done("shl1", 16'h1554, 1'b0);

    run_op("ror0", 3'd0, 4'd0, 16'h1234, 16'h1234, 1'b0, 0, -1, -1);
    after_done("ror0", 16'h1234, 1'b0);
    run_op("pass7", 3'd7, 4'd5, 16'h0000, 16'h0000, 1'b0, 0, -1, -1);
    after_done("pass7", 16'h0000, 1'b0);
    run_op("asr3neg", 3'd4, 4'd3, 16'h8010, 16'hF002, 1'b0, 3, -1, -1);
    after_done("asr3neg", 16'hF002, 1'b0);

    // start pulses at busy cycles 2 and 5 must be dropped
    run_op("ror8_ign", 3'd0, 4'd8, 16'h00FF, 16'hFF00, 1'b1, 8, 1, 4);
    after_done("ror8_ign", 16'hFF00, 1'b1);

    // asynchronous reset during busy cycle 3 of an amt=10 operation
    chk("ar_ready_before", ready, 1);
    start = 1'b1; op = 3'd0; amt = 4'd10; data_in = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ar_busy1", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("ar_busy3", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", ready, 1);
    chk("ar_done", done, 0);
    chk("ar_result", result, 16'h0000);
    chk("ar_carry", carry, 0);
    chk("ar_zero", zero, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_idle_after", dbg_state, 2'd0);
    run_op("post_rst", 3'd0, 4'd1, 16'h8001, 16'hC000, 1'b1, 1, -1, -1);
    after_done("post_rst", 16'hC000, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_barrel_rotator.md
Name: seq_barrel_rotator

Overview:
Multi-cycle, parametrised shift/rotate unit for the CPU datapath. It generalises the fixed-amount combinational rotate-right to five operations, a runtime shift amount and width N. It executes one bit-step per clock under a start/ready/done handshake. The ALU sequencer uses it for shift instructions and consumes the result and carry/zero flags.

Parameters:
N, 16, data width in bits
AW, 4, shift-amount width; integration requirement 2**AW == N (no internal check)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when ready=1
op  input  3  000 ROR, 001 ROL, 010 SHR logical, 011 SHL, 100 ASR, 101-111 pass-through
amt  input  AW  shift/rotate amount, 0..N-1
data_in  input  N  operand
ready  output  1  unit can accept start (state IDLE or DONE)
busy  output  1  shifting in progress (state BUSY)
done  output  1  one-cycle pulse, result valid
result  output  N  shifted value; held until the next accept
carry  output  1  last bit shifted or rotated out; 0 if amt=0 or op is pass-through
zero  output  1  result == 0; combinational from result

Behaviour:
- States: IDLE, BUSY, DONE. Reset values: state IDLE, ready 1, busy 0, done 0, result 0, carry 0, zero 1.
- Reset is asynchronous. Asserting reset mid-operation clears all state immediately and the operation is lost.
- Accept edge E0 (start=1 and ready=1 at a rising edge):
  - Load result<=data_in and carry<=0; latch op; cnt<=amt.
  - If amt=0 or op is pass-through: next state DONE.
  - Otherwise: next state BUSY.
- BUSY: each edge performs one step on result and decrements cnt. When cnt reaches 1 the final step is taken and the state goes to DONE.
- Latency: for amt=k>0, done is high in the cycle after edge Ek (k cycles after the accept edge). For k=0, done is high in the cycle after E0.
- Single steps:
  - ROR: result <= {result[0], result[N-1:1]}, carry <= result[0].
  - ROL: result <= {result[N-2:0], result[N-1]}, carry <= result[N-1].
  - SHR: result <= {1'b0, result[N-1:1]}, carry <= result[0].
  - SHL: result <= {result[N-2:0], 1'b0}, carry <= result[N-1].
  - ASR: result <= {result[N-1], result[N-1:1]}, carry <= result[0].
- DONE lasts exactly one cycle with done=1, then goes to IDLE. result and carry remain stable until the next accept edge.
- start in the DONE cycle is accepted (back-to-back operation). done still pulses for that one cycle.
- start while busy=1 is ignored, not queued. op, amt and data_in are don't-care outside the accept edge.
- ready = ~busy at all times. done and busy are never both 1.

Test Plan:
- N=16, ROR, data_in=0x00FF, amt=4 -> busy high for 4 cycles, then done pulse; result=0xF00F, carry=1, zero=0.
- ASR, 0xC003, amt=1 -> result=0xE001, carry=1, done 1 cycle after accept. Then SHR, 0xFF00, amt=15 issued in the DONE cycle -> accepted, result=0x0001 after 15 cycles, carry=1.
- ROL, 0x3C0C, amt=8 -> result=0x0C3C, carry=0. SHL, 0x0AAA, amt=1 -> result=0x1554, carry=0.
- amt=0 with op ROR on 0x1234, and op=111 with amt=5 on 0x0000 -> done in cycle after accept, busy never high, carry=0. Second case gives result=0x0000 and zero=1.
- Start ROR 0x00FF amt=8, then pulse start with new operands at busy cycles 2 and 5 -> both ignored; result=0xFF00 after 8 cycles.
- Assert reset asynchronously during busy cycle 3 of an amt=10 operation -> immediately busy=0, ready=1, done=0, result=0, zero=1. A new start after reset release operates normally.
